// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - debounced pushbutton front end with press, release, held and auto-repeat events
// Raw active-low pins are synchronized, debounced against a shared 1 ms tick and turned into one-cycle pulses.
module button_event_gen #(
  parameter int NUM_BTN         = 3,
  parameter int CLK_SPEED       = 100000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_MS       = 100,
  parameter int REPEAT_EN       = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] SW,
  output logic [NUM_BTN-1:0] PRESS,
  output logic [NUM_BTN-1:0] RELEASE,
  output logic [NUM_BTN-1:0] HELD,
  output logic               TICK
);

  localparam int PS_W   = $clog2(CLK_SPEED + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int RP_MAX = (REPEAT_DELAY_MS > REPEAT_MS) ? REPEAT_DELAY_MS : REPEAT_MS;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_SPEED - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY_MS - 1);
  localparam logic [RP_W-1:0] RM_LAST = RP_W'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  logic [NUM_BTN-1:0] sync_a;
  logic [NUM_BTN-1:0] sync_b;
  logic [PS_W-1:0]    ps_cnt;
  logic [PS_W-1:0]    ps_next;
  logic [NUM_BTN-1:0] commit;

  state_t          state  [NUM_BTN];
  logic [DB_W-1:0] db_cnt [NUM_BTN];
  logic [RP_W-1:0] rp_cnt [NUM_BTN];

  always_comb begin
    ps_next = (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
  end

  // TICK is registered from the next count so it lines up with ps_cnt == CLK_SPEED-1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a <= '0;
      sync_b <= '0;
      ps_cnt <= '0;
      TICK   <= 1'b0;
    end else begin
      sync_a <= ~SW;
      sync_b <= sync_a;
      ps_cnt <= ps_next;
      TICK   <= (ps_next == PS_LAST);
    end
  end

  // commit marks the edge where the debounced level flips on this bit.
  always_comb begin
    commit = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      commit[i] = (sync_b[i] != HELD[i]) && TICK && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PRESS   <= '0;
      RELEASE <= '0;
      HELD    <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i]  <= IDLE;
        db_cnt[i] <= '0;
        rp_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        PRESS[i]   <= 1'b0;
        RELEASE[i] <= 1'b0;

        if (sync_b[i] == HELD[i]) begin
          db_cnt[i] <= '0;
        end else if (TICK) begin
          if (db_cnt[i] == DB_LAST) begin
            db_cnt[i] <= '0;
            HELD[i]   <= sync_b[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end

        // IDLE tracks HELD==0, so a commit there is always a press and elsewhere a release.
        if (state[i] == IDLE) begin
          if (commit[i]) begin
            PRESS[i]  <= 1'b1;
            rp_cnt[i] <= '0;
            state[i]  <= DELAY;
          end
        end else if (commit[i]) begin
          RELEASE[i] <= 1'b1;
          rp_cnt[i]  <= '0;
          state[i]   <= IDLE;
        end else if (TICK && REPEAT_EN != 0) begin
          if (state[i] == DELAY) begin
            if (rp_cnt[i] == RD_LAST) begin
              PRESS[i]  <= 1'b1;
              rp_cnt[i] <= '0;
              state[i]  <= REPEAT;
            end else begin
              rp_cnt[i] <= rp_cnt[i] + RP_W'(1);
            end
          end else begin
            if (rp_cnt[i] == RM_LAST) begin
              PRESS[i]  <= 1'b1;
              rp_cnt[i] <= '0;
            end else begin
              rp_cnt[i] <= rp_cnt[i] + RP_W'(1);
            end
          end
        end
      end
    end
  end

endmodule
